// File: rtl/vpu_sram_addr_gen_pkg.sv
// Shared types and address-mapping helpers for the VPU operand SRAM read path.
// The mapping helpers take the log2 geometry as arguments so any parametrisation can reuse them.
package vpu_sram_addr_gen_pkg;

  localparam int unsigned VPU_ADDR_WIDTH   = 24;
  localparam int unsigned VPU_BANK_CNT     = 4;
  localparam int unsigned VPU_BANK_DEPTH   = 1024;
  localparam int unsigned VPU_DATA_WIDTH   = 512;
  localparam int unsigned VPU_PORT_CNT     = 3;
  localparam int unsigned VPU_LEN_WIDTH    = 6;
  localparam int unsigned VPU_STRIDE_WIDTH = 8;

  localparam int unsigned SRAM_LINE_CNT_LG2 = $clog2(VPU_BANK_CNT * VPU_BANK_DEPTH);

  typedef enum logic {
    BANK_MAP_INTERLEAVE = 1'b0,
    BANK_MAP_CONTIG     = 1'b1
  } vpu_bank_map_mode_t;

  typedef enum logic [1:0] {
    AGEN_IDLE  = 2'd0,
    AGEN_ISSUE = 2'd1,
    AGEN_DONE  = 2'd2
  } vpu_agen_state_t;

  typedef struct packed {
    logic [VPU_PORT_CNT-1:0]                     rvalid;
    logic [VPU_PORT_CNT-1:0][VPU_ADDR_WIDTH-1:0] raddr;
    logic [VPU_LEN_WIDTH-1:0]                    len;
    logic [VPU_STRIDE_WIDTH-1:0]                 stride;
    vpu_bank_map_mode_t                          mode;
  } vpu_rd_req_t;

  // Bits above the line field and the in-line offset are dropped.
  function automatic logic [31:0] get_line_idx(input logic [63:0] addr,
                                               input int unsigned off_lg2,
                                               input int unsigned line_lg2);
    logic [63:0] mask;
    mask = (64'd1 << line_lg2) - 64'd1;
    return 32'((addr >> off_lg2) & mask);
  endfunction

  function automatic logic [31:0] get_bank_id_m(input logic [31:0] line,
                                                input vpu_bank_map_mode_t mode,
                                                input int unsigned bank_lg2,
                                                input int unsigned line_lg2);
    logic [31:0] mask;
    mask = (32'd1 << bank_lg2) - 32'd1;
    if (mode == BANK_MAP_CONTIG)
      return (line >> (line_lg2 - bank_lg2)) & mask;
    return line & mask;
  endfunction

  function automatic logic [31:0] get_row_m(input logic [31:0] line,
                                            input vpu_bank_map_mode_t mode,
                                            input int unsigned bank_lg2,
                                            input int unsigned line_lg2);
    logic [31:0] line_m;
    line_m = line & ((32'd1 << line_lg2) - 32'd1);
    if (mode == BANK_MAP_CONTIG)
      return line_m & ((32'd1 << (line_lg2 - bank_lg2)) - 32'd1);
    return line_m >> bank_lg2;
  endfunction

endpackage

// File: rtl/vpu_bank_conflict_arb.sv
// Greedy same-bank conflict filter: picks pending ports from port 0 upward,
// skipping any port whose bank is already claimed in this group.
module vpu_bank_conflict_arb
  import vpu_sram_addr_gen_pkg::*;
#(
  parameter int unsigned PORT_CNT = 3,
  parameter int unsigned BANK_CNT = 4
) (
  input  logic [PORT_CNT-1:0]                        pending,
  input  logic [PORT_CNT-1:0][$clog2(BANK_CNT)-1:0]  bank_ids,
  output logic [PORT_CNT-1:0]                        group
);

  logic [BANK_CNT-1:0] used;

  always_comb begin
    used  = '0;
    group = '0;
    for (int p = 0; p < int'(PORT_CNT); p++) begin
      if (pending[p] && !used[bank_ids[p]]) begin
        group[p]           = 1'b1;
        used[bank_ids[p]]  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/vpu_sram_addr_gen.sv
// Multi-port operand SRAM read-address sequencer: streams per-beat {bank,row}
// groups for up to PORT_CNT ports, serialising same-bank collisions.
module vpu_sram_addr_gen
  import vpu_sram_addr_gen_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH   = 24,
  parameter int unsigned BANK_CNT     = 4,
  parameter int unsigned BANK_DEPTH   = 1024,
  parameter int unsigned DATA_WIDTH   = 512,
  parameter int unsigned PORT_CNT     = 3,
  parameter int unsigned LEN_WIDTH    = 6,
  parameter int unsigned STRIDE_WIDTH = 8
) (
  input  logic                                          clk,
  input  logic                                          rst,
  input  logic                                          req_valid,
  output logic                                          req_ready,
  input  logic [PORT_CNT-1:0]                           req_rvalid,
  input  logic [PORT_CNT-1:0][ADDR_WIDTH-1:0]           req_raddr,
  input  logic [LEN_WIDTH-1:0]                          req_len,
  input  logic [STRIDE_WIDTH-1:0]                       req_stride,
  input  logic                                          req_mode,
  output logic [PORT_CNT-1:0]                           rd_valid,
  output logic [PORT_CNT-1:0][$clog2(BANK_CNT)-1:0]     rd_bank_id,
  output logic [PORT_CNT-1:0][$clog2(BANK_DEPTH)-1:0]   rd_row,
  output logic [LEN_WIDTH-1:0]                          rd_beat,
  output logic                                          rd_last,
  input  logic                                          rd_ready,
  output logic                                          busy,
  output logic                                          done
);

  localparam int unsigned BANK_LG2  = $clog2(BANK_CNT);
  localparam int unsigned DEPTH_LG2 = $clog2(BANK_DEPTH);
  localparam int unsigned OFF_LG2   = $clog2(DATA_WIDTH);
  localparam int unsigned LINE_LG2  = $clog2(BANK_CNT * BANK_DEPTH);

  vpu_agen_state_t                     state_q;
  vpu_bank_map_mode_t                  mode_q;
  logic [PORT_CNT-1:0]                 active_q;
  logic [PORT_CNT-1:0]                 pend_q;
  logic [PORT_CNT-1:0][LINE_LG2-1:0]   acc_q;
  logic [LEN_WIDTH-1:0]                beat_q;
  logic [LEN_WIDTH-1:0]                len_q;
  logic [STRIDE_WIDTH-1:0]             stride_q;

  vpu_bank_map_mode_t                  cand_mode;
  logic [PORT_CNT-1:0]                 cand_pend;
  logic [PORT_CNT-1:0][LINE_LG2-1:0]   cand_acc;
  logic [LEN_WIDTH-1:0]                cand_beat;
  logic [LEN_WIDTH-1:0]                cand_len;
  logic [PORT_CNT-1:0]                 remaining;

  logic [PORT_CNT-1:0][BANK_LG2-1:0]   bank_c;
  logic [PORT_CNT-1:0][DEPTH_LG2-1:0]  row_c;
  logic [PORT_CNT-1:0]                 group_c;
  logic [PORT_CNT-1:0][BANK_LG2-1:0]   out_bank;
  logic [PORT_CNT-1:0][DEPTH_LG2-1:0]  out_row;
  logic                                last_c;

  // The candidate is whatever the sequencer would present after the next
  // taken edge: a freshly latched request, the next beat, or the rest of
  // the current beat. Outputs are registered from it so they are stable.
  always_comb begin
    remaining = pend_q & ~rd_valid;
    cand_mode = mode_q;
    cand_pend = remaining;
    cand_acc  = acc_q;
    cand_beat = beat_q;
    cand_len  = len_q;
    if (state_q == AGEN_IDLE) begin
      cand_mode = vpu_bank_map_mode_t'(req_mode);
      cand_pend = req_rvalid;
      cand_beat = '0;
      cand_len  = req_len;
      for (int p = 0; p < int'(PORT_CNT); p++)
        cand_acc[p] = LINE_LG2'(get_line_idx(64'(req_raddr[p]), OFF_LG2, LINE_LG2));
    end else if (remaining == '0) begin
      cand_pend = active_q;
      cand_beat = beat_q + LEN_WIDTH'(1);
      for (int p = 0; p < int'(PORT_CNT); p++)
        cand_acc[p] = acc_q[p] + LINE_LG2'(stride_q);
    end
  end

  always_comb begin
    for (int p = 0; p < int'(PORT_CNT); p++) begin
      bank_c[p] = BANK_LG2'(get_bank_id_m(32'(cand_acc[p]), cand_mode, BANK_LG2, LINE_LG2));
      row_c[p]  = DEPTH_LG2'(get_row_m(32'(cand_acc[p]), cand_mode, BANK_LG2, LINE_LG2));
    end
  end

  vpu_bank_conflict_arb #(
    .PORT_CNT (PORT_CNT),
    .BANK_CNT (BANK_CNT)
  ) u_arb (
    .pending  (cand_pend),
    .bank_ids (bank_c),
    .group    (group_c)
  );

  always_comb begin
    for (int p = 0; p < int'(PORT_CNT); p++) begin
      out_bank[p] = group_c[p] ? bank_c[p] : '0;
      out_row[p]  = group_c[p] ? row_c[p]  : '0;
    end
    last_c = (cand_beat == cand_len - LEN_WIDTH'(1)) && ((cand_pend & ~group_c) == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= AGEN_IDLE;
      mode_q     <= BANK_MAP_INTERLEAVE;
      active_q   <= '0;
      pend_q     <= '0;
      acc_q      <= '0;
      beat_q     <= '0;
      len_q      <= '0;
      stride_q   <= '0;
      req_ready  <= 1'b1;
      rd_valid   <= '0;
      rd_bank_id <= '0;
      rd_row     <= '0;
      rd_beat    <= '0;
      rd_last    <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      case (state_q)
        AGEN_IDLE: begin
          if (req_valid && req_ready) begin
            mode_q    <= cand_mode;
            active_q  <= req_rvalid;
            pend_q    <= cand_pend;
            acc_q     <= cand_acc;
            beat_q    <= '0;
            len_q     <= req_len;
            stride_q  <= req_stride;
            req_ready <= 1'b0;
            busy      <= 1'b1;
            if (req_len == '0 || req_rvalid == '0) begin
              state_q <= AGEN_DONE;
              done    <= 1'b1;
            end else begin
              state_q    <= AGEN_ISSUE;
              rd_valid   <= group_c;
              rd_bank_id <= out_bank;
              rd_row     <= out_row;
              rd_beat    <= cand_beat;
              rd_last    <= last_c;
            end
          end
        end
        AGEN_ISSUE: begin
          if (rd_ready) begin
            if (rd_last) begin
              state_q    <= AGEN_DONE;
              done       <= 1'b1;
              rd_valid   <= '0;
              rd_bank_id <= '0;
              rd_row     <= '0;
              rd_beat    <= '0;
              rd_last    <= 1'b0;
            end else begin
              pend_q     <= cand_pend;
              acc_q      <= cand_acc;
              beat_q     <= cand_beat;
              rd_valid   <= group_c;
              rd_bank_id <= out_bank;
              rd_row     <= out_row;
              rd_beat    <= cand_beat;
              rd_last    <= last_c;
            end
          end
        end
        AGEN_DONE: begin
          state_q   <= AGEN_IDLE;
          done      <= 1'b0;
          busy      <= 1'b0;
          req_ready <= 1'b1;
        end
        default: begin
          state_q    <= AGEN_IDLE;
          done       <= 1'b0;
          busy       <= 1'b0;
          req_ready  <= 1'b1;
          rd_valid   <= '0;
          rd_bank_id <= '0;
          rd_row     <= '0;
          rd_beat    <= '0;
          rd_last    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vpu_sram_addr_gen.sv
// Bench for vpu_sram_addr_gen: directed scenarios plus random requests checked
// against a line/bank arithmetic model of the expected read groups.
module tb_vpu_sram_addr_gen;
  import vpu_sram_addr_gen_pkg::*;

  localparam int LINES = 4096;
  localparam int DEPTH = 1024;
  localparam int BANKS = 4;
  localparam int OFF   = 9;

  typedef struct {
    logic [2:0]      valid;
    logic [2:0][1:0] bank;
    logic [2:0][9:0] row;
    int              beat;
    bit              last;
  } exp_t;

  logic             clk;
  logic             rst;
  logic             req_valid;
  logic             req_ready;
  logic [2:0]       req_rvalid;
  logic [2:0][23:0] req_raddr;
  logic [5:0]       req_len;
  logic [7:0]       req_stride;
  logic             req_mode;
  logic [2:0]       rd_valid;
  logic [2:0][1:0]  rd_bank_id;
  logic [2:0][9:0]  rd_row;
  logic [5:0]       rd_beat;
  logic             rd_last;
  logic             rd_ready;
  logic             busy;
  logic             done;

  logic [2:0]       arb_pend;
  logic [2:0][1:0]  arb_bank;
  logic [2:0]       arb_group;

  int   errors = 0;
  int   checks = 0;
  exp_t exp_q[$];

  vpu_sram_addr_gen dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_rvalid (req_rvalid),
    .req_raddr  (req_raddr),
    .req_len    (req_len),
    .req_stride (req_stride),
    .req_mode   (req_mode),
    .rd_valid   (rd_valid),
    .rd_bank_id (rd_bank_id),
    .rd_row     (rd_row),
    .rd_beat    (rd_beat),
    .rd_last    (rd_last),
    .rd_ready   (rd_ready),
    .busy       (busy),
    .done       (done)
  );

  vpu_bank_conflict_arb #(.PORT_CNT(3), .BANK_CNT(4)) arb (
    .pending  (arb_pend),
    .bank_ids (arb_bank),
    .group    (arb_group)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  function automatic logic [2:0] greedyGroup(input logic [2:0] pend, input logic [2:0][1:0] bank);
    bit         used[BANKS];
    logic [2:0] g;
    g = '0;
    for (int b = 0; b < BANKS; b++) used[b] = 1'b0;
    for (int p = 0; p < 3; p++) begin
      if (pend[p] && !used[bank[p]]) begin
        g[p] = 1'b1;
        used[bank[p]] = 1'b1;
      end
    end
    return g;
  endfunction

  function automatic void buildExpected(input vpu_rd_req_t r);
    exp_q.delete();
    if (r.len == 0 || r.rvalid == 0) return;
    for (int k = 0; k < int'(r.len); k++) begin
      logic [2:0][1:0] b;
      logic [2:0][9:0] rw;
      logic [2:0]      pend;
      logic [2:0]      g;
      exp_t            e;
      for (int p = 0; p < 3; p++) begin
        int line;
        line = (int'(r.raddr[p] >> OFF) + k * int'(r.stride)) % LINES;
        if (r.mode == BANK_MAP_CONTIG) begin
          b[p]  = 2'(line / DEPTH);
          rw[p] = 10'(line % DEPTH);
        end else begin
          b[p]  = 2'(line % BANKS);
          rw[p] = 10'(line / BANKS);
        end
      end
      pend = r.rvalid;
      while (pend != 0) begin
        g       = greedyGroup(pend, b);
        pend    = pend & ~g;
        e.valid = g;
        e.bank  = b;
        e.row   = rw;
        e.beat  = k;
        e.last  = (k == int'(r.len) - 1) && (pend == 0);
        exp_q.push_back(e);
      end
    end
  endfunction

  function automatic vpu_rd_req_t mkReq(input logic [2:0] rv, input logic [23:0] a0, input logic [23:0] a1,
                                        input logic [23:0] a2, input logic [5:0] len, input logic [7:0] st,
                                        input vpu_bank_map_mode_t m);
    vpu_rd_req_t r;
    r.rvalid   = rv;
    r.raddr[0] = a0;
    r.raddr[1] = a1;
    r.raddr[2] = a2;
    r.len      = len;
    r.stride   = st;
    r.mode     = m;
    return r;
  endfunction

  task automatic applyStimulus(input vpu_rd_req_t r);
    req_valid  = 1'b1;
    req_rvalid = r.rvalid;
    req_raddr  = r.raddr;
    req_len    = r.len;
    req_stride = r.stride;
    req_mode   = r.mode;
  endtask

  task automatic checkEntry(input exp_t e);
    checkOutput("rd_valid", 32'(rd_valid), 32'(e.valid));
    for (int p = 0; p < 3; p++) begin
      if (e.valid[p]) begin
        checkOutput($sformatf("rd_bank_id[%0d]", p), 32'(rd_bank_id[p]), 32'(e.bank[p]));
        checkOutput($sformatf("rd_row[%0d]", p), 32'(rd_row[p]), 32'(e.row[p]));
      end
    end
    checkOutput("rd_beat", 32'(rd_beat), 32'(e.beat));
    checkOutput("rd_last", 32'(rd_last), 32'(e.last));
    checkOutput("done_during_issue", 32'(done), 32'd0);
    checkOutput("req_ready_busy", 32'(req_ready), 32'd0);
  endtask

  // Sits at a negedge in IDLE on entry and returns at a negedge in IDLE.
  task automatic runRequest(input vpu_rd_req_t r, input int stall_idx, input int stall_len, input bit rand_stall);
    buildExpected(r);
    checkOutput("req_ready_idle", 32'(req_ready), 32'd1);
    applyStimulus(r);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    for (int i = 0; i < exp_q.size(); i++) begin
      int stalls;
      if (i == stall_idx) stalls = stall_len;
      else if (rand_stall) stalls = int'($urandom_range(0, 2));
      else stalls = 0;
      for (int s = 0; s <= stalls; s++) begin
        checkEntry(exp_q[i]);
        rd_ready  = (s == stalls);
        req_valid = rand_stall ? 1'($urandom_range(0, 1)) : 1'b0;
        @(posedge clk);
        @(negedge clk);
        rd_ready  = 1'b0;
        req_valid = 1'b0;
      end
    end
    checkOutput("done_pulse", 32'(done), 32'd1);
    checkOutput("rd_valid_in_done", 32'(rd_valid), 32'd0);
    checkOutput("req_ready_in_done", 32'(req_ready), 32'd0);
    checkOutput("busy_in_done", 32'(busy), 32'd1);
    req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    checkOutput("done_cleared", 32'(done), 32'd0);
    checkOutput("req_ready_back", 32'(req_ready), 32'd1);
    checkOutput("busy_cleared", 32'(busy), 32'd0);
    checkOutput("rd_valid_idle", 32'(rd_valid), 32'd0);
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_req_ready"}, 32'(req_ready), 32'd1);
    checkOutput({tag, "_rd_valid"}, 32'(rd_valid), 32'd0);
    checkOutput({tag, "_rd_bank_id"}, 32'(rd_bank_id), 32'd0);
    checkOutput({tag, "_rd_row"}, 32'(rd_row), 32'd0);
    checkOutput({tag, "_rd_beat"}, 32'(rd_beat), 32'd0);
    checkOutput({tag, "_rd_last"}, 32'(rd_last), 32'd0);
    checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
    checkOutput({tag, "_done"}, 32'(done), 32'd0);
  endtask

  initial begin
    vpu_rd_req_t r;
    rst        = 1'b1;
    req_valid  = 1'b0;
    req_rvalid = '0;
    req_raddr  = '0;
    req_len    = '0;
    req_stride = '0;
    req_mode   = 1'b0;
    rd_ready   = 1'b0;
    arb_pend   = '0;
    arb_bank   = '0;

    // Standalone arbiter: one all-conflict vector, then random masks and banks.
    arb_pend = 3'b111;
    arb_bank = {2'd2, 2'd2, 2'd2};
    #1;
    checkOutput("arb_all_same_bank", 32'(arb_group), 32'(greedyGroup(arb_pend, arb_bank)));
    for (int i = 0; i < 16; i++) begin
      arb_pend = 3'($urandom);
      arb_bank = 6'($urandom);
      #1;
      checkOutput("arb_random", 32'(arb_group), 32'(greedyGroup(arb_pend, arb_bank)));
    end

    @(posedge clk);
    @(negedge clk);
    checkResetState("reset");
    rst = 1'b0;
    @(negedge clk);

    $display("[TB] mode 0, three distinct banks, len 1");
    runRequest(mkReq(3'b111, 24'h000000, 24'h000200, 24'h000400, 6'd1, 8'd1, BANK_MAP_INTERLEAVE), -1, 0, 1'b0);

    $display("[TB] mode 0, all ports on one line, len 2");
    runRequest(mkReq(3'b111, 24'h000000, 24'h000000, 24'h000000, 6'd2, 8'd1, BANK_MAP_INTERLEAVE), -1, 0, 1'b0);

    $display("[TB] mode 1, crossing into bank 1");
    runRequest(mkReq(3'b001, 24'(1023 << OFF), 24'h0, 24'h0, 6'd3, 8'd1, BANK_MAP_CONTIG), -1, 0, 1'b0);

    $display("[TB] mode 1, line index wrap");
    runRequest(mkReq(3'b001, 24'(4095 << OFF), 24'h0, 24'h0, 6'd2, 8'd1, BANK_MAP_CONTIG), -1, 0, 1'b0);

    $display("[TB] five-cycle rd_ready stall mid-stream");
    runRequest(mkReq(3'b111, 24'h000000, 24'h000000, 24'h000000, 6'd2, 8'd1, BANK_MAP_INTERLEAVE), 2, 5, 1'b0);

    $display("[TB] empty requests");
    runRequest(mkReq(3'b111, 24'h000000, 24'h000200, 24'h000400, 6'd0, 8'd1, BANK_MAP_INTERLEAVE), -1, 0, 1'b0);
    runRequest(mkReq(3'b000, 24'h000000, 24'h000200, 24'h000400, 6'd5, 8'd1, BANK_MAP_INTERLEAVE), -1, 0, 1'b0);

    $display("[TB] reset during beat 3 of len 8");
    r = mkReq(3'b001, 24'h012345, 24'h0, 24'h0, 6'd8, 8'd3, BANK_MAP_INTERLEAVE);
    buildExpected(r);
    checkOutput("req_ready_before_abort", 32'(req_ready), 32'd1);
    applyStimulus(r);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checkEntry(exp_q[i]);
      rd_ready = 1'b1;
      if (i == 3) rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rd_ready = 1'b0;
    end
    rst = 1'b0;
    checkResetState("abort");
    @(posedge clk);
    @(negedge clk);
    checkOutput("abort_no_done", 32'(done), 32'd0);
    runRequest(mkReq(3'b011, 24'h000600, 24'h000800, 24'h0, 6'd3, 8'd2, BANK_MAP_INTERLEAVE), -1, 0, 1'b0);

    $display("[TB] random requests");
    for (int n = 0; n < 24; n++) begin
      r.rvalid   = 3'($urandom_range(0, 7));
      r.raddr[0] = 24'($urandom);
      r.raddr[1] = 24'($urandom);
      r.raddr[2] = 24'($urandom);
      r.len      = 6'($urandom_range(0, 6));
      r.stride   = 8'($urandom);
      r.mode     = ($urandom_range(0, 1) == 1) ? BANK_MAP_CONTIG : BANK_MAP_INTERLEAVE;
      runRequest(r, -1, 0, 1'b1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
